// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator's derivative datapath.
package calc_pkg;

   localparam int ORD_W_DEF = 3;
   localparam int MAX_ORDER = (1 << ORD_W_DEF) - 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STEP,
      EMIT
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/deriv_step_mul.sv
// One derivative step: acc * e, clamped to all ones when the product overflows OUT_W.
module deriv_step_mul #(
   parameter int OUT_W = 16,
   parameter int EXP_W = 4
) (
   input  logic [OUT_W-1:0] i_acc,
   input  logic [EXP_W-1:0] i_e,
   output logic [OUT_W-1:0] o_prod,
   output logic             o_ovf
);

   logic [OUT_W+EXP_W-1:0] w_full;

   assign w_full = {{EXP_W{1'b0}}, i_acc} * {{OUT_W{1'b0}}, i_e};
   assign o_ovf  = |w_full[OUT_W+EXP_W-1:OUT_W];
   assign o_prod = o_ovf ? {OUT_W{1'b1}} : w_full[OUT_W-1:0];

endmodule

// File: rtl/poly_derivative.sv
// Iterative k-th order derivative of a TERMS-monomial polynomial, streamed out one term at a time.
module poly_derivative
   import calc_pkg::*;
#(
   parameter int COEF_W = 8,
   parameter int EXP_W  = 4,
   parameter int TERMS  = 4,
   parameter int ORD_W  = 3,
   parameter int OUT_W  = 16,
   localparam int IDX_W = (clog2(TERMS) > 0) ? clog2(TERMS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [TERMS*COEF_W-1:0] in_coef,
   input  logic [TERMS*EXP_W-1:0]  in_exp,
   input  logic [ORD_W-1:0]        in_order,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_coef,
   output logic [EXP_W-1:0]        out_exp,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_last,
   output logic                    out_ovf
);

   state_t r_state, w_state_next;

   logic [TERMS*COEF_W-1:0] r_coef;
   logic [TERMS*EXP_W-1:0]  r_exp;
   logic [ORD_W-1:0]        r_order;
   logic [ORD_W-1:0]        r_step;
   logic [IDX_W-1:0]        r_idx;
   logic [OUT_W-1:0]        r_acc;
   logic [EXP_W-1:0]        r_e;
   logic                    r_ovf;

   logic [COEF_W-1:0] w_coef_arr [TERMS];
   logic [EXP_W-1:0]  w_exp_arr  [TERMS];
   logic [COEF_W-1:0] w_sel_coef;
   logic [EXP_W-1:0]  w_sel_exp;
   logic              w_zero;
   logic              w_last_term;
   logic [OUT_W-1:0]  w_prod;
   logic              w_mul_ovf;

   genvar gi;
   generate
      for (gi = 0; gi < TERMS; gi++) begin : g_unpack
         assign w_coef_arr[gi] = r_coef[gi*COEF_W +: COEF_W];
         assign w_exp_arr[gi]  = r_exp[gi*EXP_W +: EXP_W];
      end
   endgenerate

   assign w_sel_coef  = w_coef_arr[r_idx];
   assign w_sel_exp   = w_exp_arr[r_idx];
   // exp >= k is what keeps the exponent from wrapping during STEP
   assign w_zero      = (w_sel_coef == '0) || (32'(w_sel_exp) < 32'(r_order));
   assign w_last_term = (r_idx == IDX_W'(TERMS - 1));

   deriv_step_mul #(
      .OUT_W (OUT_W),
      .EXP_W (EXP_W)
   ) u_mul (
      .i_acc  (r_acc),
      .i_e    (r_e),
      .o_prod (w_prod),
      .o_ovf  (w_mul_ovf)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (in_valid) w_state_next = LOAD;
         LOAD: w_state_next = (w_zero || r_order == '0) ? EMIT : STEP;
         STEP: if (r_step == ORD_W'(1)) w_state_next = EMIT;
         EMIT: if (out_ready) w_state_next = w_last_term ? IDLE : LOAD;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_coef  <= '0;
         r_exp   <= '0;
         r_order <= '0;
         r_step  <= '0;
         r_idx   <= '0;
         r_acc   <= '0;
         r_e     <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_coef  <= in_coef;
                  r_exp   <= in_exp;
                  r_order <= in_order;
                  r_idx   <= '0;
               end
            end
            LOAD: begin
               r_ovf  <= 1'b0;
               r_step <= r_order;
               if (w_zero) begin
                  r_acc <= '0;
                  r_e   <= '0;
               end else begin
                  r_acc <= OUT_W'(w_sel_coef);
                  r_e   <= w_sel_exp;
               end
            end
            STEP: begin
               // a saturated accumulator stays pinned for the remaining steps
               r_acc  <= r_ovf ? {OUT_W{1'b1}} : w_prod;
               r_ovf  <= r_ovf | w_mul_ovf;
               r_e    <= r_e - 1'b1;
               r_step <= r_step - 1'b1;
            end
            EMIT: begin
               if (out_ready && !w_last_term) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == EMIT);
   assign out_coef  = r_acc;
   assign out_exp   = r_e;
   assign out_idx   = r_idx;
   assign out_ovf   = r_ovf;
   assign out_last  = (r_state == EMIT) && w_last_term;

endmodule

// File: tb/tb_poly_derivative.sv
// Directed bench for poly_derivative: model results queued on send, compared as terms stream out.
module tb_poly_derivative;
   import calc_pkg::*;

   localparam int COEF_W = 8;
   localparam int EXP_W  = 4;
   localparam int TERMS  = 4;
   localparam int ORD_W  = 3;
   localparam int OUT_W  = 16;
   localparam int IDX_W  = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [TERMS*COEF_W-1:0] in_coef;
   logic [TERMS*EXP_W-1:0]  in_exp;
   logic [ORD_W-1:0]        in_order;
   logic                    out_valid;
   logic                    out_ready;
   logic [OUT_W-1:0]        out_coef;
   logic [EXP_W-1:0]        out_exp;
   logic [IDX_W-1:0]        out_idx;
   logic                    out_last;
   logic                    out_ovf;

   always #5 clk = ~clk;

   poly_derivative #(
      .COEF_W (COEF_W),
      .EXP_W  (EXP_W),
      .TERMS  (TERMS),
      .ORD_W  (ORD_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coef   (in_coef),
      .in_exp    (in_exp),
      .in_order  (in_order),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_coef  (out_coef),
      .out_exp   (out_exp),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_ovf   (out_ovf)
   );

   typedef struct packed {
      logic [OUT_W-1:0] coef;
      logic [EXP_W-1:0] ex;
      logic [IDX_W-1:0] idx;
      logic             last;
      logic             ovf;
      int               wait_cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic void push_poly(input logic [TERMS*COEF_W-1:0] c,
                                     input logic [TERMS*EXP_W-1:0] e, input int k);
      for (int i = 0; i < TERMS; i++) begin
         exp_t   t;
         int     ci;
         int     ei;
         longint acc;
         ci = int'(c[i*COEF_W +: COEF_W]);
         ei = int'(e[i*EXP_W +: EXP_W]);
         t.idx  = IDX_W'(i);
         t.last = (i == TERMS - 1);
         t.ovf  = 1'b0;
         if (ci == 0 || ei < k) begin
            t.coef     = '0;
            t.ex       = '0;
            t.wait_cyc = 1;
         end else begin
            acc = ci;
            for (int s = 0; s < k; s++) begin
               acc = acc * (ei - s);
               if (acc > 65535) begin
                  acc   = 65535;
                  t.ovf = 1'b1;
               end
            end
            t.coef     = OUT_W'(acc);
            t.ex       = EXP_W'(ei - k);
            t.wait_cyc = k + 1;
         end
         sb.push_back(t);
      end
   endfunction

   task automatic send(input logic [TERMS*COEF_W-1:0] c, input logic [TERMS*EXP_W-1:0] e,
                       input int k);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("accept_ready", in_ready, 1);
      in_coef  = c;
      in_exp   = e;
      in_order = ORD_W'(k);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("in_ready_drop", in_ready, 0);
      push_poly(c, e, k);
   endtask

   task automatic drain(input int hold);
      exp_t t;
      int   n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=output expected=none");
         return;
      end
      t = sb.pop_front();
      check($sformatf("t%0d_valid", t.idx), out_valid, 1);
      check($sformatf("t%0d_wait", t.idx), n, t.wait_cyc);
      check($sformatf("t%0d_coef", t.idx), out_coef, t.coef);
      check($sformatf("t%0d_exp", t.idx), out_exp, t.ex);
      check($sformatf("t%0d_idx", t.idx), out_idx, t.idx);
      check($sformatf("t%0d_last", t.idx), out_last, t.last);
      check($sformatf("t%0d_ovf", t.idx), out_ovf, t.ovf);
      check($sformatf("t%0d_busy", t.idx), in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_coef", out_coef, t.coef);
         check("hold_exp", out_exp, t.ex);
         check("hold_idx", out_idx, t.idx);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (t.last) check("idle_ready", in_ready, 1);
      else        check("gap_low", out_valid, 0);
      $display("term idx=%0d coef=%0d exp=%0d ovf=%0d last=%0d", t.idx, out_coef, out_exp,
               t.ovf, t.last);
   endtask

   task automatic drain_all();
      for (int i = 0; i < TERMS; i++) drain(0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_coef   = '0;
      in_exp    = '0;
      in_order  = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_coef", out_coef, 0);
      check("rst_out_exp", out_exp, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_ovf", out_ovf, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // k=1 mixed terms, including coef==0 and exp<k
      send({8'd2, 8'd0, 8'd5, 8'd3}, {4'd0, 4'd3, 4'd1, 4'd4}, 1);
      drain_all();

      // k=2, single live term
      send({8'd0, 8'd0, 8'd0, 8'd7}, {4'd5, 4'd2, 4'd9, 4'd3}, 2);
      drain_all();

      // k=0 pass-through
      send({8'd4, 8'd3, 8'd2, 8'd1}, {4'd8, 4'd7, 4'd6, 4'd5}, 0);
      drain_all();

      // k=7 saturation on terms 0 and 2
      send({8'd1, 8'd3, 8'd1, 8'd255}, {4'd3, 4'd9, 4'd7, 4'd15}, 7);
      drain_all();

      // backpressure on term 1
      send({8'd9, 8'd8, 8'd7, 8'd6}, {4'd5, 4'd4, 4'd3, 4'd2}, 2);
      drain(0);
      drain(5);
      drain(0);
      drain(0);

      // reset while term 2 is stepping
      send({8'd1, 8'd2, 8'd3, 8'd4}, {4'd6, 4'd5, 4'd4, 4'd3}, 3);
      drain(0);
      drain(0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_coef", out_coef, 0);
      check("mid_rst_out_exp", out_exp, 0);
      check("mid_rst_out_idx", out_idx, 0);
      check("mid_rst_out_last", out_last, 0);
      check("mid_rst_out_ovf", out_ovf, 0);

      send({8'd10, 8'd20, 8'd30, 8'd40}, {4'd1, 4'd2, 4'd3, 4'd4}, 1);
      drain_all();

      for (int r = 0; r < 3; r++) begin
         send(TERMS*COEF_W'($urandom), TERMS*EXP_W'($urandom), int'($urandom_range(0, 7)));
         drain_all();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
